// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply/divide unit for the LC-3b datapath.
// All additions and complements go through an external ALU. Shifts, the compare and sequencing are done here.
typedef enum logic [2:0] {
  alu_add, alu_and, alu_not, alu_passa, alu_passb, alu_sll, alu_srl, alu_sra
} lc3b_aluop;

module alu_muldiv_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output lc3b_aluop        alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_f
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, NEG_NOT, NEG_INC, ITER, DONE} state_t;

  state_t           state_reg, state_next;
  logic             op_reg;
  logic [WIDTH-1:0] acc_reg, mcand_reg, mplier_reg;
  logic [WIDTH-1:0] r_reg, q_reg, divisor_reg, negdiv_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH:0]   rs;
  logic             rs_ge;
  logic             last_iter;
  logic [WIDTH-1:0] q_next, r_next;

  // Restoring-divide step: the compare is 17 bits wide so the carry out of r is not lost.
  assign rs        = {r_reg, q_reg[WIDTH-1]};
  assign rs_ge     = (rs >= {1'b0, divisor_reg});
  assign q_next    = {q_reg[WIDTH-2:0], rs_ge};
  assign r_next    = rs_ge ? alu_f : rs[WIDTH-1:0];
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (!op)               state_next = ITER;
          else if (src_b != '0)  state_next = NEG_NOT;
          else                   state_next = DONE;
        end
      end
      NEG_NOT: state_next = NEG_INC;
      NEG_INC: state_next = ITER;
      ITER:    state_next = last_iter ? DONE : ITER;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    alu_op = alu_passa;
    alu_a  = '0;
    alu_b  = '0;
    case (state_reg)
      NEG_NOT: begin
        busy   = 1'b1;
        alu_op = alu_not;
        alu_a  = divisor_reg;
      end
      NEG_INC: begin
        busy   = 1'b1;
        alu_op = alu_add;
        alu_a  = negdiv_reg;
        alu_b  = WIDTH'(1);
      end
      ITER: begin
        busy = 1'b1;
        if (op_reg) begin
          alu_op = alu_add;
          alu_a  = rs[WIDTH-1:0];
          alu_b  = negdiv_reg;
        end else if (mplier_reg[0]) begin
          alu_op = alu_add;
          alu_a  = acc_reg;
          alu_b  = mcand_reg;
        end else begin
          alu_op = alu_passa;
          alu_a  = acc_reg;
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_reg      <= 1'b0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      divisor_reg <= '0;
      negdiv_reg  <= '0;
      cnt_reg     <= '0;
      result      <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg      <= op;
            div_by_zero <= 1'b0;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            mcand_reg   <= src_a;
            mplier_reg  <= src_b;
            r_reg       <= '0;
            q_reg       <= src_a;
            divisor_reg <= src_b;
            if (op && src_b == '0) begin
              result      <= '1;
              remainder   <= src_a;
              div_by_zero <= 1'b1;
            end
          end
        end
        NEG_NOT, NEG_INC: negdiv_reg <= alu_f;
        ITER: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (op_reg) begin
            q_reg <= q_next;
            r_reg <= r_next;
            if (last_iter) begin
              result    <= q_next;
              remainder <= r_next;
            end
          end else begin
            acc_reg    <= alu_f;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            if (last_iter) begin
              result    <= alu_f;
              remainder <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural LC-3b ALU attached to its ALU port.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [15:0] src_a, src_b;
  logic        busy, done, div_by_zero;
  logic [15:0] result, remainder;
  lc3b_aluop   alu_op;
  logic [15:0] alu_a, alu_b, alu_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .result(result), .remainder(remainder), .div_by_zero(div_by_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f)
  );

  always_comb begin
    case (alu_op)
      alu_add:   alu_f = alu_a + alu_b;
      alu_and:   alu_f = alu_a & alu_b;
      alu_not:   alu_f = ~alu_a;
      alu_passa: alu_f = alu_a;
      alu_passb: alu_f = alu_b;
      alu_sll:   alu_f = alu_a << alu_b[3:0];
      alu_srl:   alu_f = alu_a >> alu_b[3:0];
      alu_sra:   alu_f = $unsigned($signed(alu_a) >>> alu_b[3:0]);
      default:   alu_f = alu_a;
    endcase
  end

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] rem;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for done; returns with the DUT back in IDLE.
  task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int busy_cnt, output logic busy_at_done,
                        output logic [15:0] res, output logic [15:0] rem, output logic dbz,
                        output logic timeout);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; busy_cnt = 0; timeout = 1'b0;
    while (!done) begin
      if (busy) busy_cnt++;
      if (lat >= 60) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    busy_at_done = busy;
    res = result; rem = remainder; dbz = div_by_zero;
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat, bcnt, dones;
    logic        bdone, dbz, tmo;
    logic [15:0] res, rem, seen_res;

    vecs[0]  = '{1'b0, 16'd3,    16'd5,    16'd15,   16'd0,    1'b0, 17};
    vecs[1]  = '{1'b0, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b0, 17};
    vecs[2]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17};
    vecs[3]  = '{1'b0, 16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 1'b0, 17};
    vecs[4]  = '{1'b0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 17};
    vecs[5]  = '{1'b1, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 19};
    vecs[6]  = '{1'b1, 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0, 19};
    vecs[7]  = '{1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 19};
    vecs[8]  = '{1'b1, 16'd5,    16'd9,    16'd0,    16'd5,    1'b0, 19};
    vecs[9]  = '{1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1};
    vecs[10] = '{1'b0, 16'd7,    16'd9,    16'd63,   16'd0,    1'b0, 17};
    vecs[11] = '{1'b1, 16'd1000, 16'd10,   16'd100,  16'd0,    1'b0, 19};

    reset_n = 1'b0; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_alu_op", alu_op, alu_passa);
    check("rst_alu_a", alu_a, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, bdone, res, rem, dbz, tmo);
      $display("vec %0d: op=%0d a=%h b=%h -> result=%h rem=%h dbz=%0d lat=%0d busy=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, res, rem, dbz, lat, bcnt);
      check("timeout", tmo, 0);
      check("result", res, vecs[i].res);
      check("remainder", rem, vecs[i].rem);
      check("div_by_zero", dbz, vecs[i].dbz);
      check("latency", lat, vecs[i].lat);
      check("busy_cycles", bcnt, vecs[i].lat - 1);
      check("busy_at_done", bdone, 0);
      check("result_hold", result, vecs[i].res);
    end

    // ALU requests while negating the divisor (100 / 7).
    @(negedge clk);
    start = 1'b1; op = 1'b1; src_a = 16'd100; src_b = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("neg_not_op", alu_op, alu_not);
    check("neg_not_a", alu_a, 16'd7);
    @(posedge clk); #1;
    check("neg_inc_op", alu_op, alu_add);
    check("neg_inc_a", alu_a, 16'hFFF8);
    check("neg_inc_b", alu_b, 16'h0001);
    lat = 2;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("seq div: 100/7 -> result=%h rem=%h lat=%0d", result, remainder, lat);
    check("div_seq_lat", lat, 19);
    check("div_seq_result", result, 16'd14);
    @(posedge clk); #1;

    // Start pulses while busy and in the DONE cycle must be ignored.
    @(negedge clk);
    start = 1'b1; op = 1'b0; src_a = 16'd3; src_b = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 1'b1; src_a = 16'd50; src_b = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; seen_res = '0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        dones++;
        seen_res = result;
        if (dones == 1) begin
          start = 1'b1; op = 1'b1; src_a = 16'd9; src_b = 16'd0;
        end
      end
    end
    $display("seq ignore: dones=%0d result=%h dbz=%0d", dones, seen_res, div_by_zero);
    check("ignore_dones", dones, 1);
    check("ignore_result", seen_res, 16'd15);
    check("ignore_dbz", div_by_zero, 0);

    // Asynchronous abort mid-iteration, then a clean operation.
    @(negedge clk);
    start = 1'b1; op = 1'b0; src_a = 16'h1234; src_b = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    $display("seq abort: busy=%0d done=%0d result=%h", busy, done, result);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_remainder", remainder, 0);
    check("abort_alu_op", alu_op, alu_passa);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(1'b0, 16'd3, 16'd5, lat, bcnt, bdone, res, rem, dbz, tmo);
    $display("seq after abort: 3*5 -> result=%h lat=%0d", res, lat);
    check("post_abort_timeout", tmo, 0);
    check("post_abort_result", res, 16'd15);
    check("post_abort_lat", lat, 17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle unsigned 16-bit multiply/divide unit for the LC-3b datapath.
- Acts as the initiator on the ALU interface. It drives aluop/a/b to a dedicated ALU instance and consumes f every cycle, so all additions and complements go through that ALU.
- Shifting, comparison and sequencing are local.
- The control FSM launches an operation with a start pulse and waits for a done pulse.

Parameters:
- WIDTH, 16, operand/result width (lc3b_word); iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  launch request; sampled only in IDLE
- op  in  1  0 = multiply, 1 = divide (both unsigned)
- src_a  in  16  multiplicand / dividend
- src_b  in  16  multiplier / divisor
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle completion pulse
- result  out  16  low 16 bits of product / quotient
- remainder  out  16  divide remainder; 0 after multiply
- div_by_zero  out  1  set with done when divisor = 0; held until next accept
- alu_op  out  lc3b_aluop  operation requested of ALU
- alu_a  out  16  ALU operand a
- alu_b  out  16  ALU operand b
- alu_f  in  16  ALU result; combinational, same cycle

Behaviour:
- Reset (async assert, sync deassert use):
  - state = IDLE.
  - busy = done = div_by_zero = 0; result = remainder = 0.
  - All internal registers cleared.
- ALU outputs by state:
  - In IDLE and DONE: alu_op = alu_passa, alu_a = alu_b = 0.
- States: IDLE, NEG_NOT, NEG_INC, ITER, DONE.
- IDLE:
  - start=1 latches operands and clears div_by_zero.
  - op=0 → ITER with acc=0, mcand=src_a, mplier=src_b.
  - op=1 with src_b≠0 → NEG_NOT with r=0, q=src_a, divisor=src_b.
  - op=1 with src_b=0 → DONE with result=16'hFFFF, remainder=src_a, div_by_zero=1.
- NEG_NOT (divide only): alu_op=alu_not, alu_a=divisor; negdiv <= alu_f.
- NEG_INC: alu_op=alu_add, alu_a=negdiv, alu_b=16'h0001; negdiv <= alu_f; → ITER.
- ITER runs a 5-bit counter for exactly 16 cycles, then → DONE.
- Multiply, per ITER cycle:
  - mplier[0]=1: alu_op=alu_add, alu_a=acc, alu_b=mcand.
  - mplier[0]=0: alu_op=alu_passa, alu_a=acc.
  - acc <= alu_f; mcand <<= 1 (bits shifted out dropped); mplier >>= 1.
  - Product is truncated mod 2^16.
- Divide (restoring), per ITER cycle:
  - rs = {r, q[15]} (17 bits); q <<= 1.
  - alu_op=alu_add, alu_a=rs[15:0], alu_b=negdiv.
  - If rs >= {0,divisor} (local 17-bit compare): r <= alu_f and q[0] <= 1.
  - Otherwise: r <= rs[15:0] and q[0] <= 0.
  - rs < 2·divisor always, so the remainder fits 16 bits.
- Entering DONE:
  - result <= acc (mul) or q (div); remainder <= 0 (mul) or r (div).
  - done=1 for that one cycle; busy=0; → IDLE.
- Latency, counted from the start-sampling edge to the cycle done is high:
  - multiply: 17 cycles
  - divide: 19 cycles
  - divide by zero: 1 cycle
- start during busy/DONE is ignored and not queued. A start in the same cycle as DONE is ignored; accept is from IDLE only.
- result, remainder and div_by_zero hold their values until the next accepted start. busy and the outputs are not registered into ALU timing; alu_f is consumed the same cycle.
- reset_n low mid-operation aborts immediately to the reset values. No done is issued.

Test Plan:
- mul src_a=3, src_b=5 → done exactly 17 cycles after start, result=15, remainder=0, busy high for 16 cycles.
- mul 16'h0100 × 16'h0100 → result=16'h0000 (truncation); mul 16'hFFFF × 16'hFFFF → result=16'h0001.
- div 100 / 7 → done at 19 cycles, result=14, remainder=2; in NEG_NOT alu_op=alu_not with alu_a=7, in NEG_INC alu_a=16'hFFF8.
- div 16'hFFFF / 16'h8001 → result=1, remainder=16'h7FFE (17-bit compare carry path); div 16'hFFFF / 1 → result=16'hFFFF, remainder=0.
- div src_a=16'h1234, src_b=0 → done 1 cycle later, result=16'hFFFF, remainder=16'h1234, div_by_zero=1; next mul clears div_by_zero.
- start pulsed during an ongoing mul → ignored, single done with original result. reset_n low at iteration 8 → busy/done/result=0 immediately, IDLE; the next start completes normally.
